// File: rtl/axi_burst_checker_pkg.sv
// Shared types for the AXI burst checker: FSM states, AXI channel structs
// at the default widths, and the per-beat data pattern generator.
package axi_burst_checker_pkg;

    localparam int unsigned AxiAddrWidth = 64;
    localparam int unsigned AxiDataWidth = 128;
    localparam int unsigned AxiIdWidth   = 6;
    localparam int unsigned AxiUserWidth = 2;
    localparam int unsigned MaxDataWidth = 1024;

    localparam logic [1:0] BurstIncr = 2'b01;
    localparam logic [1:0] RespOkay  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R
    } state_e;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic [5:0]              atop;
        logic [AxiUserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [AxiDataWidth-1:0]   data;
        logic [AxiDataWidth/8-1:0] strb;
        logic                      last;
        logic [AxiUserWidth-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [1:0]              resp;
        logic [AxiUserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic [AxiUserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiDataWidth-1:0] data;
        logic [1:0]              resp;
        logic                    last;
        logic [AxiUserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_resp_t;

    // Word (seed + index) replicated across the low data_width bits; upper bits are zero.
    function automatic logic [MaxDataWidth-1:0] beat_data(
        input logic [31:0] seed,
        input logic [8:0]  index,
        input int unsigned data_width
    );
        logic [31:0]             word;
        logic [MaxDataWidth-1:0] data;
        word = seed + 32'(index);
        data = '0;
        for (int unsigned i = 0; i < MaxDataWidth / 32; i++) begin
            if (i < data_width / 32) begin
                data[i*32 +: 32] = word;
            end
        end
        return data;
    endfunction

endpackage

// File: rtl/axi_burst_checker.sv
// Issues one INCR write burst with a seeded pattern, reads it back and
// flags response, ID, last-beat and data errors.
module axi_burst_checker
    import axi_burst_checker_pkg::*;
#(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned IdWidth   = 6,
    parameter int unsigned UserWidth = 2,
    parameter type axi_req_t  = axi_burst_checker_pkg::axi_req_t,
    parameter type axi_resp_t = axi_burst_checker_pkg::axi_resp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [7:0]           len_i,
    input  logic [IdWidth-1:0]   id_i,
    input  logic [31:0]          seed_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [8:0]           mismatch_cnt_o,
    output axi_req_t             axi_req_o,
    input  axi_resp_t            axi_rsp_i
);

    localparam int unsigned BytesPerBeat = DataWidth / 8;
    localparam int unsigned OffsetBits   = $clog2(BytesPerBeat);
    localparam logic [2:0]  BeatSize     = 3'(OffsetBits);

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [7:0]             len_q, len_d;
    logic [IdWidth-1:0]     id_q, id_d;
    logic [31:0]            seed_q, seed_d;
    logic [8:0]             beat_q, beat_d;
    logic                   error_q, error_d;
    logic                   done_q, done_d;
    logic [8:0]             mismatch_q, mismatch_d;

    logic [AddrWidth-1:0]    aligned_addr;
    logic [31:0]             burst_end;
    logic                    crosses_4k;
    logic [MaxDataWidth-1:0] beat_pattern;
    logic [DataWidth-1:0]    exp_data;
    logic                    last_beat;
    logic                    unused_rsp_bits;

    assign aligned_addr = addr_i & ~AddrWidth'(BytesPerBeat - 1);
    assign burst_end    = {20'd0, aligned_addr[11:0]} + ((32'(len_i) + 32'd1) << OffsetBits);
    assign crosses_4k   = burst_end > 32'd4096;

    // One beat counter serves both the W and R phases, so the pattern follows it.
    assign beat_pattern = beat_data(seed_q, beat_q, DataWidth);
    assign exp_data     = beat_pattern[DataWidth-1:0];
    assign last_beat    = beat_q == {1'b0, len_q};

    assign unused_rsp_bits = ^{axi_rsp_i.b.user, axi_rsp_i.r.user, beat_pattern};

    assign busy_o         = state_q != ST_IDLE;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign mismatch_cnt_o = mismatch_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        id_d       = id_q;
        seed_d     = seed_q;
        beat_d     = beat_q;
        error_d    = error_q;
        done_d     = 1'b0;
        mismatch_d = mismatch_q;
        axi_req_o  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    error_d    = 1'b0;
                    mismatch_d = '0;
                    if (crosses_4k) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = aligned_addr;
                        len_d   = len_i;
                        id_d    = id_i;
                        seed_d  = seed_i;
                        beat_d  = '0;
                        state_d = ST_AW;
                    end
                end
            end

            ST_AW: begin
                axi_req_o.aw_valid = 1'b1;
                axi_req_o.aw.id    = id_q;
                axi_req_o.aw.addr  = addr_q;
                axi_req_o.aw.len   = len_q;
                axi_req_o.aw.size  = BeatSize;
                axi_req_o.aw.burst = BurstIncr;
                if (axi_rsp_i.aw_ready) begin
                    state_d = ST_W;
                end
            end

            ST_W: begin
                axi_req_o.w_valid = 1'b1;
                axi_req_o.w.data  = exp_data;
                axi_req_o.w.strb  = '1;
                axi_req_o.w.last  = last_beat;
                if (axi_rsp_i.w_ready) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = ST_B;
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end
            end

            // A bad write response is recorded but the readback still runs.
            ST_B: begin
                axi_req_o.b_ready = 1'b1;
                if (axi_rsp_i.b_valid) begin
                    if (axi_rsp_i.b.resp != RespOkay || axi_rsp_i.b.id != id_q) begin
                        error_d = 1'b1;
                    end
                    state_d = ST_AR;
                end
            end

            ST_AR: begin
                axi_req_o.ar_valid = 1'b1;
                axi_req_o.ar.id    = id_q;
                axi_req_o.ar.addr  = addr_q;
                axi_req_o.ar.len   = len_q;
                axi_req_o.ar.size  = BeatSize;
                axi_req_o.ar.burst = BurstIncr;
                if (axi_rsp_i.ar_ready) begin
                    beat_d  = '0;
                    state_d = ST_R;
                end
            end

            // Beats past len_q count as mismatches regardless of their data.
            ST_R: begin
                axi_req_o.r_ready = 1'b1;
                if (axi_rsp_i.r_valid) begin
                    if (beat_q > {1'b0, len_q} || axi_rsp_i.r.data != exp_data) begin
                        mismatch_d = mismatch_q + 9'd1;
                        error_d    = 1'b1;
                    end
                    if (axi_rsp_i.r.resp != RespOkay || axi_rsp_i.r.id != id_q) begin
                        error_d = 1'b1;
                    end
                    if (axi_rsp_i.r.last && !last_beat) begin
                        error_d = 1'b1;
                    end
                    if (beat_q != 9'h1FF) begin
                        beat_d = beat_q + 9'd1;
                    end
                    if (axi_rsp_i.r.last) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            id_q       <= '0;
            seed_q     <= '0;
            beat_q     <= '0;
            error_q    <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            id_q       <= id_d;
            seed_q     <= seed_d;
            beat_q     <= beat_d;
            error_q    <= error_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
        end
    end

endmodule
